// File: rtl/conv2d_row_sum.sv
// conv2d_row_sum
// Reduction stage behind a bank of WT_DIM conv2D row PEs. Each PE streams
// 1D partial sums with no backpressure. Every stream goes into its own
// alignment FIFO. When all FIFOs hold a word, one word is popped from each
// FIFO, and the words are added together and presented on a ready/valid
// output. A run produces fm_dim*fm_dim results and then pulses done.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   start        one-cycle pulse, accepted only in IDLE; latches fm_dim
//   fm_dim       feature-map dimension
//   pe_data_i    PE i result in bits [i*DWIDTH +: DWIDTH]
//   pe_valid_i   per-PE result valid (no ready returned)
//   out_data     summed result, held while out_valid & !out_ready
//   out_valid    out_data valid
//   out_ready    consumer accepts
//   busy         high while a run is active
//   done         one-cycle pulse after the last result is accepted
//   overflow     sticky: a PE word was dropped on a full FIFO
module conv2d_row_sum #(
    parameter int DWIDTH     = 32,
    parameter int WT_DIM     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DWIDTH-1:0]        fm_dim,
    input  logic [WT_DIM*DWIDTH-1:0] pe_data_i,
    input  logic [WT_DIM-1:0]        pe_valid_i,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]       PTR_ONE = (AW + 1)'(1);
    localparam logic [DWIDTH-1:0] CNT_ONE = DWIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [DWIDTH-1:0]          total;
    logic [DWIDTH-1:0]          pop_cnt;
    logic [DWIDTH-1:0]          acc_cnt;

    logic [DWIDTH-1:0]          mem [WT_DIM][FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]                wr_ptr [WT_DIM];
    logic [AW:0]                rd_ptr [WT_DIM];

    logic [WT_DIM-1:0]          empty;
    logic [WT_DIM-1:0]          full;
    logic [WT_DIM-1:0]          push;
    logic [WT_DIM-1:0]          drop;
    logic [WT_DIM*DWIDTH-1:0]   heads;
    logic                       pop;
    logic                       accept;
    logic                       last_accept;

    function automatic logic [DWIDTH-1:0] square_trunc(input logic [DWIDTH-1:0] d);
        return d * d;
    endfunction

    // The sum wraps modulo 2^DWIDTH. No saturation is applied.
    function automatic logic [DWIDTH-1:0] wrap_sum(input logic [WT_DIM*DWIDTH-1:0] h);
        logic [DWIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < WT_DIM; i++) begin
            s = s + h[i*DWIDTH +: DWIDTH];
        end
        return s;
    endfunction

    always_comb begin
        empty = '0;
        full  = '0;
        heads = '0;
        for (int i = 0; i < WT_DIM; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            heads[i*DWIDTH +: DWIDTH] = mem[i][rd_ptr[i][AW-1:0]];
        end
    end

    // All FIFOs pop together, so their heads stay aligned on the same output index.
    assign pop = (state == RUN) && !(|empty) && (pop_cnt < total) && (!out_valid || out_ready);

    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < WT_DIM; i++) begin
            // A full FIFO can accept a word only when it pops in the same cycle.
            push[i] = (state == RUN) && pe_valid_i[i] && (!full[i] || pop);
            drop[i] = (state == RUN) && pe_valid_i[i] && full[i] && !pop;
        end
    end

    assign accept      = out_valid && out_ready;
    assign last_accept = accept && (acc_cnt == total - CNT_ONE);

    always_ff @(posedge clk) begin
        for (int i = 0; i < WT_DIM; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= pe_data_i[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            total     <= '0;
            pop_cnt   <= '0;
            acc_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < WT_DIM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        total    <= square_trunc(fm_dim);
                        pop_cnt  <= '0;
                        acc_cnt  <= '0;
                        overflow <= 1'b0;
                        // Words left over from the previous run are flushed here.
                        for (int i = 0; i < WT_DIM; i++) begin
                            wr_ptr[i] <= '0;
                            rd_ptr[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    for (int i = 0; i < WT_DIM; i++) begin
                        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                        if (pop)     rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                    end
                    if (|drop) overflow <= 1'b1;
                    if (pop) begin
                        out_data  <= wrap_sum(heads);
                        out_valid <= 1'b1;
                        pop_cnt   <= pop_cnt + CNT_ONE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept) acc_cnt <= acc_cnt + CNT_ONE;
                    // An empty run ends on the first cycle in RUN.
                    if (total == '0 || last_accept) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_row_sum.sv
// Self-checking bench for conv2d_row_sum (WT_DIM=3, DWIDTH=32, FIFO_DEPTH=8).
module tb_conv2d_row_sum;
    localparam int DW = 32;
    localparam int WD = 3;
    localparam int FD = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  fm_dim = '0;
    logic [WD*DW-1:0] pe_data_i = '0;
    logic [WD-1:0]  pe_valid_i = '0;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           done;
    logic           overflow;

    conv2d_row_sum #(.DWIDTH(DW), .WT_DIM(WD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fm_dim(fm_dim),
        .pe_data_i(pe_data_i), .pe_valid_i(pe_valid_i),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs change just after posedge, so at negedge every value
    // shown is the value the next posedge will sample.
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    int            done_cyc[$];
    logic          done_busy[$];
    int            ov_cyc[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(busy);
            end
            if (out_valid) ov_cyc.push_back(cyc);
        end
    end

    int total_n = 0;
    int bad_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int fm, output int sc);
        fm_dim = DW'(fm);
        start  = 1'b1;
        sc     = cyc;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int dbase, input int lim, input string nm);
        int n;
        n = 0;
        while (done_cyc.size() == dbase && n < lim) begin
            step();
            n++;
        end
        chk({nm, "_done_seen"}, 64'(done_cyc.size() > dbase), 64'd1);
    endtask

    function automatic logic [DW-1:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 32'hBAD0BAD0;
    endfunction

    function automatic int gcyc_at(input int idx);
        if (idx < got_cyc.size()) return got_cyc[idx];
        return -1000;
    endfunction

    typedef struct {
        int            fm;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] sum;
    } vec_t;
    vec_t tbl[4];

    int            base, dbase, ovbase, sc, p2cyc, n, k, acc, lim;
    int            sent[WD];
    logic [DW-1:0] mq[WD][$];
    logic [DW-1:0] w[WD][16];
    logic [DW-1:0] ex, wv, held;

    initial begin
        tbl[0] = '{2, 32'd1, 32'd2, 32'd3, 32'd6};
        tbl[1] = '{1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1};
        tbl[2] = '{3, 32'd100, 32'd200, 32'd300, 32'd600};
        tbl[3] = '{2, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};

        // Reset state
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        step();

        // Table: all PEs valid together, constant values, out_ready high
        for (int t = 0; t < 4; t++) begin
            base = got_q.size(); dbase = done_cyc.size();
            do_start(tbl[t].fm, sc);
            chk("tbl_busy_run", 64'(busy), 64'd1);
            out_ready = 1'b1;
            n = tbl[t].fm * tbl[t].fm;
            for (int j = 0; j < n; j++) begin
                pe_valid_i = '1;
                pe_data_i  = {tbl[t].c, tbl[t].b, tbl[t].a};
                step();
            end
            pe_valid_i = '0;
            wait_done(dbase, 60, "tbl");
            step(); step(); step();
            chk("tbl_count", 64'(got_q.size() - base), 64'(n));
            for (int j = 0; j < n; j++) begin
                chk("tbl_sum", 64'(got_at(base + j)), 64'(tbl[t].sum));
                chk("tbl_b2b", 64'(gcyc_at(base + j) - gcyc_at(base)), 64'(j));
            end
            chk("tbl_done_once", 64'(done_cyc.size() - dbase), 64'd1);
            if (done_busy.size() > dbase) chk("tbl_busy_at_done", 64'(done_busy[dbase]), 64'd0);
            chk("tbl_busy_idle", 64'(busy), 64'd0);
        end

        // Staggered PEs: PE i is i cycles late, data 10*i+k; a start mid-run is ignored
        base = got_q.size(); dbase = done_cyc.size();
        do_start(2, sc);
        out_ready = 1'b1;
        p2cyc = 0;
        for (int j = 0; j < 6; j++) begin
            pe_valid_i = '0;
            for (int i = 0; i < WD; i++) begin
                k = j - i;
                if (k >= 0 && k < 4) begin
                    pe_valid_i[i] = 1'b1;
                    pe_data_i[i*DW +: DW] = DW'(10 * i + k);
                end
            end
            if (j == 2) p2cyc = cyc;
            start  = (j == 3);
            fm_dim = 32'd5;
            step();
        end
        start = 1'b0;
        pe_valid_i = '0;
        wait_done(dbase, 40, "stag");
        step(); step(); step();
        chk("stag_count", 64'(got_q.size() - base), 64'd4);
        for (int j = 0; j < 4; j++) begin
            chk("stag_sum", 64'(got_at(base + j)), 64'(30 + 3 * j));
            chk("stag_latency", 64'(gcyc_at(base + j)), 64'(p2cyc + 2 + j));
        end
        chk("stag_done_once", 64'(done_cyc.size() - dbase), 64'd1);

        // Backpressure and overflow: fm_dim=4, out_ready low while FIFOs fill
        for (int i = 0; i < WD; i++)
            for (int j = 0; j < 16; j++) w[i][j] = $urandom;
        base = got_q.size(); dbase = done_cyc.size();
        do_start(4, sc);
        out_ready = 1'b0;
        for (int j = 0; j < 9; j++) begin
            pe_valid_i = '1;
            for (int i = 0; i < WD; i++) pe_data_i[i*DW +: DW] = w[i][j];
            step();
        end
        chk("ovf_not_yet", 64'(overflow), 64'd0);
        pe_valid_i = 3'b001;
        pe_data_i[DW-1:0] = 32'hDEAD_BEEF;
        step();
        pe_valid_i = '0;
        chk("ovf_set", 64'(overflow), 64'd1);
        held = w[0][0] + w[1][0] + w[2][0];
        for (int j = 0; j < 5; j++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(held));
            step();
        end
        out_ready = 1'b1;
        for (int j = 9; j < 16; j++) begin
            pe_valid_i = '1;
            for (int i = 0; i < WD; i++) pe_data_i[i*DW +: DW] = w[i][j];
            step();
        end
        pe_valid_i = '0;
        wait_done(dbase, 60, "ovf");
        step();
        chk("ovf_count", 64'(got_q.size() - base), 64'd16);
        for (int j = 0; j < 16; j++) begin
            ex = w[0][j] + w[1][j] + w[2][j];
            chk("ovf_sum", 64'(got_at(base + j)), 64'(ex));
        end
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Randomized runs against a queue-based reference model
        for (int r = 0; r < 4; r++) begin
            base = got_q.size(); dbase = done_cyc.size();
            n = $urandom_range(1, 5);
            n = n * n;
            for (int i = 0; i < WD; i++) begin
                mq[i].delete();
                sent[i] = 0;
            end
            do_start($rtoi($sqrt(n)), sc);
            chk("rnd_ovf_cleared", 64'(overflow), 64'd0);
            lim = 0;
            while ((sent[0] < n || sent[1] < n || sent[2] < n) && lim < 400) begin
                acc = got_q.size() - base;
                pe_valid_i = '0;
                for (int i = 0; i < WD; i++) begin
                    if (sent[i] < n && sent[i] - acc < FD && $urandom_range(0, 3) != 0) begin
                        wv = $urandom;
                        pe_valid_i[i] = 1'b1;
                        pe_data_i[i*DW +: DW] = wv;
                        mq[i].push_back(wv);
                        sent[i]++;
                    end
                end
                out_ready = ($urandom_range(0, 2) != 0);
                step();
                lim++;
            end
            pe_valid_i = '0;
            out_ready = 1'b1;
            wait_done(dbase, 200, "rnd");
            step();
            chk("rnd_count", 64'(got_q.size() - base), 64'(n));
            for (int j = 0; j < n; j++) begin
                ex = '0;
                for (int i = 0; i < WD; i++) ex = ex + ((j < mq[i].size()) ? mq[i][j] : 32'd0);
                chk("rnd_sum", 64'(got_at(base + j)), 64'(ex));
            end
            chk("rnd_no_ovf", 64'(overflow), 64'd0);
            chk("rnd_done_once", 64'(done_cyc.size() - dbase), 64'd1);
        end

        // Reset in the middle of a run
        base = got_q.size(); dbase = done_cyc.size();
        do_start(2, sc);
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            pe_valid_i = '1;
            pe_data_i  = {32'd7, 32'd8, 32'd9};
            step();
        end
        pe_valid_i = '0;
        step(); step(); step();
        chk("mid_two_out", 64'(got_q.size() - base), 64'd2);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) step();
        chk("mid_no_done", 64'(done_cyc.size() - dbase), 64'd0);
        base = got_q.size();
        do_start(1, sc);
        pe_valid_i = '1;
        pe_data_i  = {32'd6, 32'd5, 32'd4};
        step();
        pe_valid_i = '0;
        wait_done(dbase, 30, "mid");
        step(); step();
        chk("mid_one_out", 64'(got_q.size() - base), 64'd1);
        chk("mid_sum", 64'(got_at(base)), 64'd15);
        chk("mid_done_once", 64'(done_cyc.size() - dbase), 64'd1);

        // fm_dim = 0: done two cycles after start, never out_valid
        dbase = done_cyc.size(); ovbase = ov_cyc.size(); base = got_q.size();
        do_start(0, sc);
        pe_valid_i = '1;
        pe_data_i  = {32'd1, 32'd1, 32'd1};
        step();
        pe_valid_i = '0;
        step(); step(); step();
        chk("zero_done_once", 64'(done_cyc.size() - dbase), 64'd1);
        if (done_cyc.size() > dbase) chk("zero_done_cyc", 64'(done_cyc[dbase]), 64'(sc + 2));
        chk("zero_no_valid", 64'(ov_cyc.size() - ovbase), 64'd0);
        chk("zero_no_out", 64'(got_q.size() - base), 64'd0);
        chk("zero_idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
